fetch_queue: RTL
================

# fetch_queue

First-word-fall-through instruction queue between instruction memory and the decode stage. Buffers fetched {PC, instruction} pairs so decode stalls do not block fetch. It presents the head instruction, and its `instruction[31:7]` slice, to decode and the immediate generator. A single-cycle flush empties it on branch/jump redirect.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; must be a power of two, at least 2.
- `PTR_W`, 2: log2(DEPTH); pointer width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `FLUSH` in 1: synchronous clear of all entries (redirect).
- `IMEM_VALID` in 1: fetched word valid this cycle.
- `IMEM_PC` in 32: PC of fetched word.
- `IMEM_INSTR` in 32: fetched instruction.
- `QUEUE_READY` out 1: queue can accept a push this cycle.
- `ID_READY` in 1: decode accepts the head entry this cycle (not stalled).
- `ID_VALID` out 1: head entry valid.
- `ID_PC` out 32: head PC.
- `ID_INSTR` out 32: head instruction.
- `ID_IMM_FIELD` out 25: `ID_INSTR[31:7]`, routed to the immediate generator input.
- `COUNT` out PTR_W+1: number of valid entries, 0..DEPTH.

## Operation

- Storage: DEPTH entries of {PC[31:0], INSTR[31:0]}. Write pointer `wr_ptr`, read pointer `rd_ptr`, each PTR_W bits, plus a `COUNT` register.
- Push condition: `push = IMEM_VALID & QUEUE_READY & ~FLUSH`. Writes entry[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop condition: `pop = ID_VALID & ID_READY & ~FLUSH`. Increments rd_ptr modulo DEPTH.
- `QUEUE_READY = (COUNT != DEPTH)`, derived from registered state only. When full, a push is refused even if a pop occurs in the same cycle.
- COUNT update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Pointer wrap: pointers wrap from DEPTH−1 to 0 with no gap.
- Head outputs (FWFT): `ID_VALID = (COUNT != 0)`; `ID_PC` and `ID_INSTR` = entry[rd_ptr].
- Empty queue: `ID_INSTR` = 32'h0000_0013 (NOP, addi x0,x0,0) and `ID_PC` = 0. This keeps the immediate generator input defined.
- FLUSH:
  - On the next edge, wr_ptr, rd_ptr and COUNT go to 0.
  - Any push or pop in the same cycle is discarded.
  - FLUSH has priority over everything except RESET.
- Storage contents are not cleared by FLUSH or RESET. Validity is carried only by COUNT.
- No error on push while full: the word is dropped. Fetch must honour QUEUE_READY.

## Timing

- Reset values, asynchronous on RESET high:
  - wr_ptr = 0, rd_ptr = 0, COUNT = 0.
  - Outputs: ID_VALID = 0, QUEUE_READY = 1, ID_INSTR = 32'h0000_0013, ID_PC = 0, ID_IMM_FIELD = 25'h000_0000.
- Latency without bypass: a word pushed at edge N appears on ID_* after edge N, i.e. it is visible during cycle N+1.
- Handshakes: valid/ready; a transfer occurs on the rising edge where both are high. ID_* outputs stay stable while ID_VALID=1 and ID_READY=0.
- Reset asserted mid-operation: the queue is empty immediately, without waiting for a clock edge. The first push is accepted on the first edge after RESET deasserts.
- Combinational paths:
  - ID_* depend on registered state only, plus the bypass inputs when FETCH_QUEUE_BYPASS_EN is set.
  - QUEUE_READY depends on registered state only.

## Configuration

Macro: `FETCH_QUEUE_BYPASS_EN`.

- Defined: when COUNT=0, IMEM_VALID=1 and FLUSH=0:
  - ID_VALID=1 and ID_PC/ID_INSTR = IMEM_PC/IMEM_INSTR combinationally (zero latency).
  - If ID_READY=1, the word is consumed directly and not stored; COUNT stays 0.
  - If ID_READY=0, the word is pushed normally.
- Not defined: no combinational IMEM→ID path; minimum latency is one cycle as stated in Timing.

## Test plan

- Reset: assert RESET mid-stream with COUNT=3 -> immediately COUNT=0, ID_VALID=0, ID_INSTR=32'h00000013, QUEUE_READY=1.
- Fill while decode is stalled: ID_READY=0, push PCs 0x0,0x4,0x8,0xC with instr 0x00500093 etc. -> COUNT=4, QUEUE_READY=0. A fifth push (PC 0x10) is dropped. Then ID_READY=1 drains 0x0,0x4,0x8,0xC in order.
- Wrap and simultaneous push/pop: hold COUNT=2 with continuous push and pop for 10 cycles -> COUNT stays 2, PCs exit in order 0x0..0x24, pointers wrap cleanly.
- Immediate slice: head instr 32'hFFF00093 -> ID_IMM_FIELD=25'h1FFE001.
- Flush with push in the same cycle: COUNT=3, FLUSH=1, IMEM_VALID=1 -> next cycle COUNT=0 and ID_VALID=0. A push the following cycle of PC 0x100 appears as the head.
- Bypass: queue empty, push PC 0x40 with ID_READY=1.
  - With FETCH_QUEUE_BYPASS_EN: ID_VALID=1 with ID_PC=0x40 in the same cycle, and COUNT stays 0.
  - Without it: ID_PC=0x40 appears one cycle later and COUNT goes 1→0.

Source files
------------

// File: rtl/fetch_queue.sv
// First-word-fall-through {PC, instruction} queue between instruction memory and decode.
// Optional zero-latency IMEM->ID path when the queue is empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IMEM_VALID,
    input  logic [31:0]      IMEM_PC,
    input  logic [31:0]      IMEM_INSTR,
    output logic             QUEUE_READY,
    input  logic             ID_READY,
    output logic             ID_VALID,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_INSTR,
    output logic [24:0]      ID_IMM_FIELD,
    output logic [PTR_W:0]   COUNT
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP_INSTR  = 32'h0000_0013;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    // Contents are never cleared; validity lives only in count_reg.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic stored_valid;
    logic bypass_hit;
    logic bypass_take;
    logic push;
    logic pop;

    assign stored_valid = (count_reg != '0);
    assign QUEUE_READY  = (count_reg != FULL_COUNT);
    assign COUNT        = count_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = ~stored_valid & IMEM_VALID & ~FLUSH;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word that decode takes immediately never enters storage.
    assign bypass_take = bypass_hit & ID_READY;
    assign push        = IMEM_VALID & QUEUE_READY & ~FLUSH & ~bypass_take;
    assign pop         = stored_valid & ID_READY & ~FLUSH;

    always_comb begin
        ID_VALID = stored_valid | bypass_hit;
        ID_PC    = 32'h0;
        ID_INSTR = NOP_INSTR;
        if (stored_valid) begin
            ID_PC    = pc_mem[rd_ptr_reg];
            ID_INSTR = instr_mem[rd_ptr_reg];
        end else if (bypass_hit) begin
            ID_PC    = IMEM_PC;
            ID_INSTR = IMEM_INSTR;
        end
    end

    assign ID_IMM_FIELD = ID_INSTR[31:7];

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= IMEM_PC;
            instr_mem[wr_ptr_reg] <= IMEM_INSTR;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (FLUSH) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
